// File: rtl/ranc_buf_pkg.sv
// Shared definitions for the packet-buffer FIFOs and their read-side adapters.
package ranc_buf_pkg;

  localparam int BUF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/buffer_drain_if.sv
// FIFO read port plus downstream valid/ready channel of the buffer drain adapter.
interface buffer_drain_if #(
  parameter int DATA_WIDTH = ranc_buf_pkg::BUF_DATA_WIDTH
) ();

  logic                  buf_empty;
  logic [DATA_WIDTH-1:0] buf_dout;
  logic                  buf_read_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;

  modport master (
    input  buf_empty, buf_dout, dout_ready,
    output buf_read_en, dout, dout_valid
  );

  modport slave (
    output buf_empty, buf_dout, dout_ready,
    input  buf_read_en, dout, dout_valid
  );

endinterface

// File: rtl/buffer_drain_skid.sv
// Two-entry holding stage: head register feeds downstream, skid register absorbs
// one extra word while the head is blocked. Strict FIFO order between the two.
module skid_stage
  import ranc_buf_pkg::*;
#(
  parameter int DATA_WIDTH = BUF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] hd,
  output logic                  valid,
  output occ_t                  occ
);

  occ_t                  occ_reg, occ_next;
  logic [DATA_WIDTH-1:0] hd_reg, sk_reg;
  logic                  arrival;
  logic                  load_hd_in, load_hd_sk, load_sk;

  assign arrival = in_valid && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_reg <= OCC_EMPTY;
    end else begin
      occ_reg <= occ_next;
    end
  end

  always_comb begin
    occ_next = occ_reg;
    if (flush) begin
      occ_next = OCC_EMPTY;
    end else begin
      case (occ_reg)
        OCC_EMPTY: if (arrival) occ_next = OCC_ONE;
        OCC_ONE: begin
          if (arrival && !pop)      occ_next = OCC_TWO;
          else if (!arrival && pop) occ_next = OCC_EMPTY;
        end
        OCC_TWO: if (pop && !arrival) occ_next = OCC_ONE;
        default: occ_next = OCC_EMPTY;
      endcase
    end
  end

  // Arrival lands in the head only if the head is free after this cycle's pop.
  always_comb begin
    valid      = (occ_reg != OCC_EMPTY);
    load_hd_in = 1'b0;
    load_hd_sk = 1'b0;
    load_sk    = 1'b0;
    case (occ_reg)
      OCC_EMPTY: load_hd_in = arrival;
      OCC_ONE: begin
        load_hd_in = arrival && pop;
        load_sk    = arrival && !pop;
      end
      OCC_TWO: begin
        load_hd_sk = pop;
        load_sk    = pop && arrival;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hd_reg <= '0;
      sk_reg <= '0;
    end else begin
      if (load_hd_in)      hd_reg <= in_data;
      else if (load_hd_sk) hd_reg <= sk_reg;
      if (load_sk)         sk_reg <= in_data;
    end
  end

  assign hd  = hd_reg;
  assign occ = occ_reg;

endmodule

// File: rtl/buffer_drain.sv
// Read-side adapter: pops a registered-output FIFO and streams words downstream
// on valid/ready at one word per cycle, with flush and a forwarded-packet counter.
module buffer_drain
  import ranc_buf_pkg::*;
#(
  parameter int DATA_WIDTH  = BUF_DATA_WIDTH,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  buffer_drain_if.master         bus,
  output logic [COUNT_WIDTH-1:0] pkt_count
);

  occ_t                   occ;
  logic                   inflight_reg;
  logic                   pop;
  logic                   head_valid;
  logic [DATA_WIDTH-1:0]  head_data;
  logic [2:0]             demand;
  logic                   read_en;
  logic [COUNT_WIDTH-1:0] pkt_count_reg;

  assign pop = head_valid && bus.dout_ready;

  // Issue a read only if a slot is guaranteed free when the word lands a cycle later.
  always_comb begin
    demand  = {1'b0, occ} + {2'b00, inflight_reg};
    read_en = !bus.buf_empty && !flush && !rst && (demand <= (3'd1 + {2'b00, pop}));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= read_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_reg <= '0;
    end else if (pop) begin
      pkt_count_reg <= pkt_count_reg + 1'b1;
    end
  end

  skid_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .in_valid(inflight_reg),
    .in_data (bus.buf_dout),
    .pop     (pop),
    .hd      (head_data),
    .valid   (head_valid),
    .occ     (occ)
  );

  assign bus.buf_read_en = read_en;
  assign bus.dout        = head_data;
  assign bus.dout_valid  = head_valid;
  assign pkt_count       = pkt_count_reg;

endmodule

// File: tb/tb_buffer_drain.sv
// Directed bench for buffer_drain: FIFO model in front, scoreboard queue and
// handshake monitor behind.
module tb_buffer_drain;
  import ranc_buf_pkg::*;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [CW-1:0] pkt_count;

  buffer_drain_if #(.DATA_WIDTH(DW)) bus ();

  buffer_drain #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data one cycle after read_en.
  logic [DW-1:0] mem [0:63];
  int            rd_ptr = 0;
  int            wr_ptr = 0;
  logic [DW-1:0] fifo_q_out = '0;

  assign bus.buf_empty = (rd_ptr == wr_ptr);
  assign bus.buf_dout  = fifo_q_out;

  always @(posedge clk) begin
    if (bus.buf_read_en) begin
      fifo_q_out <= mem[rd_ptr % 64];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  logic [DW-1:0] exp_q [$];
  int            checks = 0;
  int            fails = 0;
  int            hs_n = 0;
  logic [CW-1:0] cnt_model = '0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_dout = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.dout_ready = 1'b0;
    wr_ptr = rd_ptr;
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (exp_q.size() == 0 && !bus.dout_valid) break;
      step();
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: data order, counter, hold stability and overflow guard.
  always @(negedge clk) begin
    if (rst) begin
      cnt_model = '0;
      prev_hold = 1'b0;
    end else begin
      chk("pkt_count", 64'(pkt_count), 64'(cnt_model));
      if (prev_hold)
        chk("dout_stable", {31'b0, bus.dout_valid, bus.dout}, {31'b0, 1'b1, prev_dout});
      if (dut.u_skid.occ_reg == OCC_TWO)
        chk("no_overflow", 64'(dut.inflight_reg && !flush && !(bus.dout_valid && bus.dout_ready)), 64'd0);
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(bus.dout), 64'hDEAD_0000_0000);
        end else begin
          chk("dout", 64'(bus.dout), 64'(exp_q.pop_front()));
        end
        cnt_model = cnt_model + 1'b1;
        hs_n++;
      end
      prev_hold = bus.dout_valid && !bus.dout_ready && !flush;
      prev_dout = bus.dout;
    end
  end

  initial begin
    int n;
    int hs0;
    bus.dout_ready = 1'b0;
    do_reset();

    // Reset values
    @(negedge clk);
    chk("rst_read_en", 64'(bus.buf_read_en), 64'd0);
    chk("rst_dout", 64'(bus.dout), 64'd0);
    chk("rst_valid", 64'(bus.dout_valid), 64'd0);
    chk("rst_count", 64'(pkt_count), 64'd0);
    chk("rst_occ", 64'(dut.u_skid.occ_reg), 64'(OCC_EMPTY));
    chk("rst_inflight", 64'(dut.inflight_reg), 64'd0);

    // Idle drain
    step();
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(32'hA0 + i);
    @(negedge clk);
    chk("idle_read_en", 64'(bus.buf_read_en), 64'd1);
    chk("idle_valid_n0", 64'(bus.dout_valid), 64'd0);
    step();
    @(negedge clk);
    chk("idle_valid_n1", 64'(bus.dout_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("idle_valid_burst", 64'(bus.dout_valid), 64'd1);
    end
    step();
    @(negedge clk);
    chk("idle_valid_end", 64'(bus.dout_valid), 64'd0);
    chk("idle_count", 64'(pkt_count), 64'd4);

    // Backpressure
    do_reset();
    for (int i = 0; i < 8; i++) push(32'hB0 + i);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.buf_read_en) n++;
      step();
    end
    @(negedge clk);
    chk("bp_reads", 64'(n), 64'd2);
    chk("bp_dout", 64'(bus.dout), 64'hB0);
    chk("bp_valid", 64'(bus.dout_valid), 64'd1);
    chk("bp_occ", 64'(dut.u_skid.occ_reg), 64'(OCC_TWO));
    step();
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("bp_no_gap", 64'(bus.dout_valid), 64'd1);
      step();
    end
    wait_drain("bp_drain", 20);
    chk("bp_count", 64'(pkt_count), 64'd8);

    // Alternating ready
    do_reset();
    hs0 = hs_n;
    for (int i = 0; i < 16; i++) push(32'hC0 + i);
    for (int c = 0; c < 100; c++) begin
      if (exp_q.size() == 0 && !bus.dout_valid) break;
      bus.dout_ready = ~bus.dout_ready;
      step();
    end
    chk("alt_drain", 64'(exp_q.size()), 64'd0);
    chk("alt_handshakes", 64'(hs_n - hs0), 64'd16);
    @(negedge clk);
    chk("alt_count", 64'(pkt_count), 64'd0);

    // Flush with one word held and one in flight
    do_reset();
    for (int i = 0; i < 6; i++) push(32'hD0 + i);
    step();
    step();
    flush = 1'b1;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    @(negedge clk);
    chk("fl_occ", 64'(dut.u_skid.occ_reg), 64'(OCC_ONE));
    chk("fl_inflight", 64'(dut.inflight_reg), 64'd1);
    chk("fl_read_en", 64'(bus.buf_read_en), 64'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_valid_n1", 64'(bus.dout_valid), 64'd0);
    chk("fl_count", 64'(pkt_count), 64'd0);
    step();
    @(negedge clk);
    chk("fl_valid_n2", 64'(bus.dout_valid), 64'd0);
    step();
    @(negedge clk);
    chk("fl_resume", 64'(bus.dout), 64'hD2);
    bus.dout_ready = 1'b1;
    wait_drain("fl_drain", 20);
    chk("fl_count_end", 64'(pkt_count), 64'd4);

    // Counter wrap
    do_reset();
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(32'hE0 + i);
    wait_drain("wrap_drain", 40);
    @(negedge clk);
    chk("wrap_count", 64'(pkt_count), 64'd1);

    // Reset mid-stream: occ ONE with a read in flight
    do_reset();
    for (int i = 0; i < 4; i++) push(32'hF0 + i);
    step();
    step();
    @(negedge clk);
    chk("mr_occ", 64'(dut.u_skid.occ_reg), 64'(OCC_ONE));
    chk("mr_inflight", 64'(dut.inflight_reg), 64'd1);
    step();
    rst = 1'b1;
    wr_ptr = rd_ptr;
    exp_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_valid", 64'(bus.dout_valid), 64'd0);
    chk("mr_dout", 64'(bus.dout), 64'd0);
    chk("mr_count", 64'(pkt_count), 64'd0);
    chk("mr_occ_clr", 64'(dut.u_skid.occ_reg), 64'(OCC_EMPTY));
    chk("mr_inflight_clr", 64'(dut.inflight_reg), 64'd0);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      @(negedge clk);
      if (bus.dout_valid) n++;
    end
    chk("mr_no_stale", 64'(n), 64'd0);
    step();
    bus.dout_ready = 1'b1;
    push(32'h1234_5678);
    push(32'h9ABC_DEF0);
    wait_drain("mr_drain", 20);
    @(negedge clk);
    chk("mr_count_end", 64'(pkt_count), 64'd2);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
